// File: rtl/sprite_pkg.sv
// Sprite engine shared definitions: OAM word layout,
// scheduler state encoding and default sprite geometry.
package sprite_pkg;

    localparam int SPRITEREF_LSB = 0;
    localparam int SPRITEREF_MSB = 7;
    localparam int XPOS_LSB      = 8;
    localparam int XPOS_MSB      = 17;
    localparam int YPOS_LSB      = 18;
    localparam int YPOS_MSB      = 27;
    localparam int PRIORITY_BIT  = 28;
    localparam int XFLIP_BIT     = 29;
    localparam int YFLIP_BIT     = 30;
    localparam int ENABLE_BIT    = 31;

    localparam int YPOS_W        = YPOS_MSB - YPOS_LSB + 1;
    localparam int SPRITE_HEIGHT = 16;

    // Wide enough that ypos + height never wraps
    localparam int MATCH_W       = 11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_EVAL,
        S_FLUSH,
        S_DRAW,
        S_DONE
    } sched_state_e;

endpackage

// File: rtl/sprite_y_match.sv
// Vertical hit test: does a sprite starting at ypos
// cover the given display line.
module sprite_y_match
    import sprite_pkg::YPOS_W, sprite_pkg::MATCH_W;
#(
    parameter int LINE_NUMBER_WIDTH = 9,
    parameter int SPRITE_HEIGHT     = sprite_pkg::SPRITE_HEIGHT
) (
    input  logic [LINE_NUMBER_WIDTH-1:0] line,
    input  logic [YPOS_W-1:0]            ypos,
    input  logic                         enable,
    output logic                         hit
);

    logic [MATCH_W-1:0] line_x;
    logic [MATCH_W-1:0] top_x;
    logic [MATCH_W-1:0] ypos_x;

    always_comb begin
        line_x = MATCH_W'(line);
        ypos_x = MATCH_W'(ypos);
        top_x  = ypos_x + MATCH_W'(SPRITE_HEIGHT);
        hit    = enable
              && (ypos_x <= line_x)
              && (line_x < top_x);
    end

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-line sprite scheduler: scans OAM, builds the list of
// sprites hitting the line, then hands the bus to the drawer.
module sprite_line_scheduler
    import sprite_pkg::sched_state_e,
           sprite_pkg::S_IDLE,
           sprite_pkg::S_CLEAR,
           sprite_pkg::S_EVAL,
           sprite_pkg::S_FLUSH,
           sprite_pkg::S_DRAW,
           sprite_pkg::S_DONE,
           sprite_pkg::YPOS_LSB,
           sprite_pkg::YPOS_MSB,
           sprite_pkg::ENABLE_BIT;
#(
    parameter int OAM_ADDR_SIZE     = 8,
    parameter int OAM_DATA_SIZE     = 32,
    parameter int SECOND_ARRAY_SIZE = 32,
    parameter int SPRITE_HEIGHT     = sprite_pkg::SPRITE_HEIGHT,
    parameter int DISPLAY_HEIGHT    = 480,
    parameter int LINE_NUMBER_WIDTH = $clog2(DISPLAY_HEIGHT)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         line_start,
    input  logic [LINE_NUMBER_WIDTH-1:0] line_number,
    output logic [OAM_ADDR_SIZE-1:0]     oam_a,
    input  logic [OAM_DATA_SIZE-1:0]     oam_d,
    output logic                         oam_grant_drawer,
    output logic [SECOND_ARRAY_SIZE-1:0][OAM_ADDR_SIZE:0] second_array,
    output logic                         drawer_enable,
    input  logic                         drawer_done,
    output logic                         line_ready,
    output logic                         busy,
    output logic                         overflow,
    output logic                         late
);

    localparam int CNT_W = $clog2(SECOND_ARRAY_SIZE + 1);
    localparam int IDX_W = $clog2(SECOND_ARRAY_SIZE);
    localparam logic [CNT_W-1:0] CNT_MAX =
        CNT_W'(SECOND_ARRAY_SIZE);

    typedef logic [SECOND_ARRAY_SIZE-1:0][OAM_ADDR_SIZE:0] list_t;

    sched_state_e state_q, state_d;

    logic [OAM_ADDR_SIZE-1:0]     addr_q, addr_d;
    logic [OAM_ADDR_SIZE-1:0]     eval_k_q, eval_k_d;
    logic                         eval_v_q, eval_v_d;
    logic [LINE_NUMBER_WIDTH-1:0] line_q, line_d;
    logic [CNT_W-1:0]             count_q, count_d;
    list_t                        list_q, list_d;
    logic                         ovf_q, ovf_d;
    logic                         late_q, late_d;

    logic hit;
    logic unused_oam;

    // Whole word folded so unused fields stay visible to lint
    assign unused_oam = ^oam_d;

    sprite_y_match #(
        .LINE_NUMBER_WIDTH (LINE_NUMBER_WIDTH),
        .SPRITE_HEIGHT     (SPRITE_HEIGHT)
    ) u_y_match (
        .line   (line_q),
        .ypos   (oam_d[YPOS_MSB:YPOS_LSB]),
        .enable (oam_d[ENABLE_BIT]),
        .hit    (hit)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        eval_k_d = addr_q;
        eval_v_d = 1'b0;
        line_d   = line_q;
        count_d  = count_q;
        list_d   = list_q;
        ovf_d    = ovf_q;
        late_d   = late_q;

        if (line_start) begin
            if (state_q == S_IDLE) begin
                late_d = 1'b0;
                line_d = line_number;
            end else begin
                late_d = 1'b1;
            end
        end

        // Word for the address issued last cycle
        if (eval_v_q && hit) begin
            if (count_q < CNT_MAX) begin
                list_d[count_q[IDX_W-1:0]] = {eval_k_q, 1'b1};
                count_d = count_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (line_start) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                list_d  = '0;
                count_d = '0;
                ovf_d   = 1'b0;
                addr_d  = '0;
                state_d = S_EVAL;
            end
            S_EVAL: begin
                eval_v_d = 1'b1;
                addr_d   = addr_q + 1'b1;
                if (addr_q == '1) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_d = (count_d != '0) ? S_DRAW : S_DONE;
            end
            S_DRAW: begin
                if (drawer_done) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            eval_k_q <= '0;
            eval_v_q <= 1'b0;
            line_q   <= '0;
            count_q  <= '0;
            list_q   <= '0;
            ovf_q    <= 1'b0;
            late_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            eval_k_q <= eval_k_d;
            eval_v_q <= eval_v_d;
            line_q   <= line_d;
            count_q  <= count_d;
            list_q   <= list_d;
            ovf_q    <= ovf_d;
            late_q   <= late_d;
        end
    end

    assign oam_a            = (state_q == S_EVAL) ? addr_q : '0;
    assign oam_grant_drawer = (state_q == S_DRAW);
    assign drawer_enable    = (state_q == S_DRAW);
    assign line_ready       = (state_q == S_DONE);
    assign busy             = (state_q != S_IDLE);
    assign second_array     = list_q;
    assign overflow         = ovf_q;
    assign late             = late_q;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed bench for sprite_line_scheduler with a
// one-cycle-latency OAM model.
module tb_sprite_line_scheduler;

    logic            clk = 1'b0;
    logic            rst;
    logic            line_start;
    logic [8:0]      line_number;
    logic [7:0]      oam_a;
    logic [31:0]     oam_d;
    logic            oam_grant_drawer;
    logic [31:0][8:0] second_array;
    logic            drawer_enable;
    logic            drawer_done;
    logic            line_ready;
    logic            busy;
    logic            overflow;
    logic            late;

    logic [31:0] oam_mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    int lat;
    int draw_cyc;
    int grant_err;
    int guard;
    int seen;

    always #5 clk = ~clk;

    always @(posedge clk) oam_d <= oam_mem[oam_a];

    sprite_line_scheduler dut (
        .clk              (clk),
        .rst              (rst),
        .line_start       (line_start),
        .line_number      (line_number),
        .oam_a            (oam_a),
        .oam_d            (oam_d),
        .oam_grant_drawer (oam_grant_drawer),
        .second_array     (second_array),
        .drawer_enable    (drawer_enable),
        .drawer_done      (drawer_done),
        .line_ready       (line_ready),
        .busy             (busy),
        .overflow         (overflow),
        .late             (late)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d",
                     tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic en,
                                       input int y);
        mk = {en, 3'b101, 10'(y), 18'h2A5C3};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) oam_mem[i] = 32'h0;
    endtask

    // Start a line, service the drawer, return cycle of line_ready
    task automatic run_line(input int ln,
                            input int done_wait,
                            input int inject_at,
                            input logic stray,
                            output int l,
                            output int dc,
                            output int ge);
        int g;
        @(negedge clk);
        line_number = 9'(ln);
        line_start  = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        l  = 1;
        dc = 0;
        ge = 0;
        g  = 0;
        while (!line_ready && g < 3000) begin
            if (drawer_enable != oam_grant_drawer) ge++;
            if (drawer_enable) begin
                dc++;
                drawer_done = (dc > done_wait);
            end else begin
                drawer_done = stray;
            end
            line_start = (l == inject_at);
            @(negedge clk);
            l++;
            g++;
        end
        line_start  = 1'b0;
        drawer_done = 1'b0;
        check("ready_seen", line_ready, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        line_start  = 1'b0;
        line_number = '0;
        drawer_done = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk);

        check("rst_busy",  busy, 0);
        check("rst_ready", line_ready, 0);
        check("rst_late",  late, 0);
        check("rst_ovf",   overflow, 0);
        check("rst_den",   drawer_enable, 0);
        check("rst_grant", oam_grant_drawer, 0);
        check("rst_oam_a", oam_a, 0);
        check("rst_arr",   (second_array == '0), 1);
        rst = 1'b0;
        @(negedge clk);

        // Empty OAM with stray drawer_done pulses outside DRAW
        run_line(100, 0, -1, 1'b1, lat, draw_cyc, grant_err);
        check("empty_lat",  lat, 259);
        check("empty_draw", draw_cyc, 0);
        check("empty_arr",  (second_array == '0), 1);
        check("empty_ovf",  overflow, 0);
        @(negedge clk);
        check("empty_idle", busy, 0);

        // Two hits, drawer takes six cycles
        oam_mem[3] = mk(1'b1, 90);
        oam_mem[7] = mk(1'b1, 100);
        run_line(100, 5, -1, 1'b0, lat, draw_cyc, grant_err);
        check("two_lat",   lat, 265);
        check("two_draw",  draw_cyc, 6);
        check("two_grant", grant_err, 0);
        check("two_e0",    second_array[0], 9'h007);
        check("two_e1",    second_array[1], 9'h00F);
        check("two_e2v",   second_array[2][0], 0);
        repeat (4) @(negedge clk);
        check("two_hold",  second_array[1], 9'h00F);
        check("two_oam_a", oam_a, 0);

        // Last OAM slot is only seen in FLUSH
        clear_mem();
        oam_mem[255] = mk(1'b1, 95);
        run_line(100, 0, -1, 1'b0, lat, draw_cyc, grant_err);
        check("last_lat", lat, 260);
        check("last_e0",  second_array[0], 9'h1FF);
        check("last_e1v", second_array[1][0], 0);

        // Overflow: 40 hits into 32 slots
        clear_mem();
        for (int i = 0; i < 40; i++) oam_mem[i] = mk(1'b1, 0);
        run_line(15, 0, -1, 1'b0, lat, draw_cyc, grant_err);
        check("ovf_lat", lat, 260);
        check("ovf_flag", overflow, 1);
        check("ovf_e0",  second_array[0], 9'h001);
        check("ovf_e17", second_array[17], 9'h023);
        check("ovf_e31", second_array[31], 9'h03F);
        run_line(16, 0, -1, 1'b0, lat, draw_cyc, grant_err);
        check("l16_lat", lat, 259);
        check("l16_ovf", overflow, 0);
        check("l16_arr", (second_array == '0), 1);

        // No wrap for ypos near 1023, disabled sprite ignored
        clear_mem();
        oam_mem[0] = mk(1'b1, 1020);
        oam_mem[1] = mk(1'b0, 0);
        oam_mem[2] = mk(1'b1, 1012);
        oam_mem[9] = mk(1'b1, 5);
        run_line(5, 0, -1, 1'b0, lat, draw_cyc, grant_err);
        check("wrap_lat", lat, 260);
        check("wrap_e0",  second_array[0], 9'h013);
        check("wrap_e1v", second_array[1][0], 0);

        // line_start during EVAL is dropped and flagged
        clear_mem();
        run_line(100, 0, 50, 1'b0, lat, draw_cyc, grant_err);
        check("late_lat",  lat, 259);
        check("late_flag", late, 1);
        @(negedge clk);
        check("late_idle", busy, 0);
        run_line(100, 0, -1, 1'b0, lat, draw_cyc, grant_err);
        check("late_clr",  late, 0);

        // Reset in DRAW, with a colliding line_start
        oam_mem[3] = mk(1'b1, 90);
        @(negedge clk);
        line_number = 9'd100;
        line_start  = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        guard = 0;
        while (!drawer_enable && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("rd_in_draw", drawer_enable, 1);
        rst        = 1'b1;
        line_start = 1'b1;
        @(negedge clk);
        check("rd_busy",  busy, 0);
        check("rd_den",   drawer_enable, 0);
        check("rd_grant", oam_grant_drawer, 0);
        check("rd_ready", line_ready, 0);
        check("rd_late",  late, 0);
        check("rd_arr",   (second_array == '0), 1);
        rst        = 1'b0;
        line_start = 1'b0;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (line_ready || busy) seen++;
        end
        check("rd_quiet", seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_line_scheduler.md
SPRITE_LINE_SCHEDULER -- requirements
Module: sprite_line_scheduler

Interface
REQ-001 Parameters SHALL be: OAM_ADDR_SIZE, default 8, OAM address width; OAM_DATA_SIZE, default 32, OAM word width; SECOND_ARRAY_SIZE, default 32, secondary-array slots; SPRITE_HEIGHT, default 16, sprite rows; DISPLAY_HEIGHT, default 480; LINE_NUMBER_WIDTH, default $clog2(DISPLAY_HEIGHT).
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be:
- clk  in  1  sole clock
- rst  in  1  synchronous active-high reset
- line_start  in  1  one-cycle pulse requesting preparation of a line
- line_number  in  LINE_NUMBER_WIDTH  line to prepare, sampled with line_start
- oam_a  out  OAM_ADDR_SIZE  OAM read address
- oam_d  in  OAM_DATA_SIZE  OAM read data, one-cycle synchronous latency
- oam_grant_drawer  out  1  1 = drawer owns the OAM bus; 0 = scheduler owns it
- second_array  out  [SECOND_ARRAY_SIZE][OAM_ADDR_SIZE:0]  bits [OAM_ADDR_SIZE:1] = OAM address, bit [0] = valid
- drawer_enable  out  1  enable for the sprite drawer
- drawer_done  in  1  drawer completion
- line_ready  out  1  one-cycle pulse: line buffer complete
- busy  out  1  high in every state except IDLE
- overflow  out  1  more than SECOND_ARRAY_SIZE hits on the current line
- late  out  1  sticky flag: a line_start was dropped

Function
REQ-004 FSM states SHALL be IDLE, CLEAR, EVAL, FLUSH, DRAW and DONE.
REQ-005 IDLE SHALL move to CLEAR on line_start and latch line_number into line_q.
REQ-006 CLEAR (1 cycle) SHALL zero all second_array entries, the hit count and overflow.
REQ-007 EVAL SHALL drive oam_a = 0, 1, ..., 2^OAM_ADDR_SIZE-1 on consecutive cycles, then go to FLUSH.
REQ-008 FLUSH (1 cycle) SHALL evaluate the last returned word; it then goes to DRAW if count > 0, else to DONE.
REQ-009 Evaluation SHALL process the word for address k in the cycle after k was issued.
REQ-010 Word fields SHALL be: ypos = oam_d[27:18]; enable = oam_d[31].
REQ-011 Hit rule: enable = 1 AND ypos <= line_q AND line_q < ypos + SPRITE_HEIGHT, with all terms compared as 11-bit unsigned values (no wrap).
REQ-012 On a hit with count < SECOND_ARRAY_SIZE, the block SHALL write {k, 1'b1} to second_array[count] and increment count; list order is ascending OAM address.
REQ-013 On a hit with count = SECOND_ARRAY_SIZE, the hit SHALL be dropped and overflow set; scanning continues to the end.
REQ-014 DRAW SHALL hold drawer_enable = 1 and oam_grant_drawer = 1 until drawer_done is sampled high, then go to DONE.
REQ-015 drawer_enable and oam_grant_drawer SHALL be 0 in all states other than DRAW.
REQ-016 DONE (1 cycle) SHALL assert line_ready and then return to IDLE.
REQ-017 second_array and overflow SHALL hold their values until the next CLEAR.
REQ-018 Zero-hit timing, with line_start sampled at cycle 0: CLEAR at cycle 1; EVAL at cycles 2..257 (OAM_ADDR_SIZE = 8); FLUSH at cycle 258; line_ready at cycle 259; IDLE at cycle 260.
REQ-019 A line_start arriving while busy = 1 SHALL be ignored and SHALL set late.
REQ-020 late SHALL clear when a line_start is accepted in IDLE.
REQ-021 A drawer_done arriving outside DRAW SHALL be ignored.
REQ-022 oam_a SHALL be 0 whenever the scheduler owns the bus and is not in EVAL.

Reset
REQ-023 While rst = 1, the FSM SHALL go to IDLE, including when reset is asserted mid-EVAL or mid-DRAW.
REQ-024 Reset SHALL zero count, line_q, second_array, oam_a, drawer_enable, oam_grant_drawer, line_ready, busy, overflow and late.
REQ-025 A line_start coinciding with rst SHALL be ignored.

Structure
REQ-026 Package sprite_pkg SHALL hold:
- the OAM field bit positions (spriteref 7:0, xpos 17:8, ypos 27:18, priority 28, xflip 29, yflip 30, enable 31)
- the scheduler state enum
- SPRITE_HEIGHT
REQ-027 One combinational sub-module, sprite_y_match, SHALL implement the hit rule of REQ-011.
REQ-028 The OAM bus mux selected by oam_grant_drawer SHALL live outside this block.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Empty OAM, line 100 -> line_ready exactly 259 cycles after line_start; drawer_enable never high; all valid bits 0.
- Sprites at OAM 3 (ypos 90) and OAM 7 (ypos 100), line 100 -> second_array[0] = {3,1}, [1] = {7,1}, [2] valid = 0; DRAW held until drawer_done, then line_ready one cycle later.
- 40 enabled sprites, all ypos 0, line 15 -> 32 entries holding OAM 0..31; overflow = 1; line 16 -> zero hits.
- ypos 1020 or disabled sprite, line 5 -> no hit (no wraparound).
- line_start during EVAL -> ignored; late = 1; late clears on the next accepted line_start.
- rst during DRAW -> next cycle IDLE, all outputs 0, no line_ready.
